// File: rtl/edge_link_arbiter.sv
// edge_link_arbiter: shares one Edge pixel filter between the UART and SPI
// receive links. Each link has a one-byte holding slot; a round-robin FSM
// issues one pixel at a time to Edge and routes the filtered byte back to
// the link it came from.
module edge_link_arbiter #(
    parameter int unsigned EDGE_LAT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       uart_rx_valid,
    input  logic [7:0] uart_rx_data,
    input  logic       uart_tx_busy,
    output logic       uart_tx_start,
    output logic [7:0] uart_tx_data,
    input  logic       spi_rx_valid,
    input  logic [7:0] spi_rx_data,
    output logic [7:0] spi_tx_data,
    output logic       edge_en,
    output logic [7:0] edge_pixel_in,
    input  logic [7:0] edge_pixel_out,
    output logic [7:0] drop_count,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DELIVER
    } state_t;

    state_t     r_state;
    logic       r_grant_uart;
    logic       r_last_uart;
    logic [3:0] r_cnt;
    logic [7:0] r_result;
    logic [7:0] r_spi_tx;

    logic       r_uart_pend;
    logic [7:0] r_uart_byte;
    logic       r_spi_pend;
    logic [7:0] r_spi_byte;
    logic [7:0] r_drop;

    logic       w_issue;
    logic       w_uart_clr;
    logic       w_spi_clr;
    logic       w_uart_drop;
    logic       w_spi_drop;
    logic [8:0] w_drop_sum;

    assign w_issue    = (r_state == ST_ISSUE);
    assign w_uart_clr = w_issue & r_grant_uart;
    assign w_spi_clr  = w_issue & ~r_grant_uart;
    // A slot being issued this cycle counts as free, so a same-cycle pulse reloads it
    assign w_uart_drop = uart_rx_valid & r_uart_pend & ~w_uart_clr;
    assign w_spi_drop  = spi_rx_valid & r_spi_pend & ~w_spi_clr;
    assign w_drop_sum  = {1'b0, r_drop} + {8'b0, w_uart_drop} + {8'b0, w_spi_drop};

    // UART holding slot: load when free, clear when issued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_uart_pend <= 1'b0;
            r_uart_byte <= '0;
        end else if (uart_rx_valid && (!r_uart_pend || w_uart_clr)) begin
            r_uart_pend <= 1'b1;
            r_uart_byte <= uart_rx_data;
        end else if (w_uart_clr) begin
            r_uart_pend <= 1'b0;
        end
    end

    // SPI holding slot: load when free, clear when issued
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_spi_pend <= 1'b0;
            r_spi_byte <= '0;
        end else if (spi_rx_valid && (!r_spi_pend || w_spi_clr)) begin
            r_spi_pend <= 1'b1;
            r_spi_byte <= spi_rx_data;
        end else if (w_spi_clr) begin
            r_spi_pend <= 1'b0;
        end
    end

    // Saturating overflow counter, up to two drops per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop <= '0;
        end else begin
            r_drop <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
        end
    end

    // Arbitration FSM: grant, issue, wait for Edge latency, deliver
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_grant_uart <= 1'b0;
            r_last_uart  <= 1'b0;
            r_cnt        <= '0;
            r_result     <= '0;
            r_spi_tx     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_uart_pend || r_spi_pend) begin
                        r_grant_uart <= r_uart_pend & (~r_spi_pend | ~r_last_uart);
                        r_state      <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_last_uart <= r_grant_uart;
                    r_cnt       <= 4'(EDGE_LAT - 1);
                    r_state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_result <= edge_pixel_out;
                        r_state  <= ST_DELIVER;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_DELIVER: begin
                    if (!r_grant_uart) begin
                        r_spi_tx <= r_result;
                        r_state  <= ST_IDLE;
                    end else if (!uart_tx_busy) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign edge_en       = w_issue;
    assign edge_pixel_in = w_issue ? (r_grant_uart ? r_uart_byte : r_spi_byte) : 8'h00;
    assign uart_tx_start = (r_state == ST_DELIVER) & r_grant_uart & ~uart_tx_busy;
    assign uart_tx_data  = r_result;
    assign spi_tx_data   = r_spi_tx;
    assign drop_count    = r_drop;
    assign busy          = (r_state != ST_IDLE) | r_uart_pend | r_spi_pend;

endmodule
